// File: rtl/uart_cmd_parser.sv
// Line-oriented ASCII command parser fed by a UART receiver byte strobe.
// Assembles terminated lines and decodes menu, toggle and duty-load commands.
`timescale 1ns/1ps
module uart_cmd_parser #(
  parameter int MAXLEN  = 4,
  parameter int TIMEOUT = 1000000,
  parameter int CW      = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       menu_req,
  output logic [2:0] menu_sel,
  output logic [1:0] out_bits,
  output logic [7:0] duty,
  output logic       duty_load,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int LW = $clog2(MAXLEN + 1);
  localparam int IW = $clog2(MAXLEN);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISCARD, S_EXEC} state_t;

  // Handshake: rx_valid is a one-cycle strobe with no back-pressure; a byte
  // is consumed in every state on the cycle rx_valid is high.
  state_t          state;
  logic [LW-1:0]   len;
  logic [CW-1:0]   to_cnt;
  logic [7:0]      line_q [MAXLEN];

  logic       is_term;
  logic       timed_out;
  logic       pending;
  logic [7:0] c0, c1, c2;

  assign is_term   = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign pending   = (state == S_COLLECT) || (state == S_DISCARD);
  assign timed_out = (to_cnt == CW'(TIMEOUT - 1));
  assign c0 = line_q[0];
  assign c1 = line_q[1];
  assign c2 = line_q[2];

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  // Letters have bit 6 set; their low nibble is 1..6 for A..F / a..f.
  function automatic logic [3:0] hex_nib(input logic [7:0] c);
    return c[6] ? (c[3:0] + 4'd9) : c[3:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      len       <= '0;
      to_cnt    <= '0;
      menu_req  <= 1'b0;
      menu_sel  <= '0;
      out_bits  <= '0;
      duty      <= '0;
      duty_load <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
      busy      <= 1'b0;
    end else begin
      menu_req  <= 1'b0;
      duty_load <= 1'b0;
      err       <= 1'b0;
      if (rx_valid || !pending) to_cnt <= '0;
      else                      to_cnt <= to_cnt + CW'(1);

      case (state)
        S_IDLE: begin
          if (rx_valid && !is_term) begin
            line_q[0] <= rx_data;
            len       <= LW'(1);
            state     <= S_COLLECT;
            busy      <= 1'b1;
          end
        end
        S_COLLECT, S_DISCARD: begin
          if (rx_valid) begin
            if (is_term) begin
              busy <= 1'b0;
              if (state == S_DISCARD) begin
                err      <= 1'b1;
                err_code <= 2'd2;
                len      <= '0;
                state    <= S_IDLE;
              end else begin
                state <= S_EXEC;
              end
            end else if (state == S_COLLECT) begin
              if (len < LW'(MAXLEN)) begin
                line_q[len[IW-1:0]] <= rx_data;
                len                 <= len + LW'(1);
              end else begin
                state <= S_DISCARD;
              end
            end
          end else if (timed_out) begin
            err      <= 1'b1;
            err_code <= 2'd3;
            len      <= '0;
            to_cnt   <= '0;
            state    <= S_IDLE;
            busy     <= 1'b0;
          end
        end
        S_EXEC: begin
          if (len == LW'(1) && c0 >= 8'h31 && c0 <= 8'h35) begin
            menu_req <= 1'b1;
            menu_sel <= c0[2:0];
          end else if (len == LW'(1) && c0 == 8'h36) begin
            out_bits[0] <= ~out_bits[0];
          end else if (len == LW'(1) && c0 == 8'h37) begin
            out_bits[1] <= ~out_bits[1];
          end else if (c0 == 8'h44 || c0 == 8'h64) begin
            if (len == LW'(3) && is_hex(c1) && is_hex(c2)) begin
              duty      <= {hex_nib(c1), hex_nib(c2)};
              duty_load <= 1'b1;
            end else begin
              err      <= 1'b1;
              err_code <= 2'd1;
            end
          end else begin
            err      <= 1'b1;
            err_code <= 2'd0;
          end
          len   <= '0;
          state <= S_IDLE;
          // A byte arriving during EXEC starts the next line immediately.
          if (rx_valid && !is_term) begin
            line_q[0] <= rx_data;
            len       <= LW'(1);
            state     <= S_COLLECT;
            busy      <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed test-plan steps followed by random lines,
// all scored against a line-level reference model.
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  localparam int MAXLEN  = 4;
  localparam int TIMEOUT = 16;
  localparam int CW      = 5;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       menu_req, duty_load, err, busy;
  logic [2:0] menu_sel;
  logic [1:0] out_bits, err_code;
  logic [7:0] duty;

  always #5 clk = ~clk;

  uart_cmd_parser #(.MAXLEN(MAXLEN), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .menu_req(menu_req), .menu_sel(menu_sel), .out_bits(out_bits),
    .duty(duty), .duty_load(duty_load), .err(err), .err_code(err_code),
    .busy(busy)
  );

  // ---------------- scoreboard ----------------
  // Event word: {kind[3:0], value[7:0]}; kind 1 menu, 2 duty, 3 out_bits, 4 err.
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [1:0] prev_bits = 2'b00;
  always @(posedge clk) begin
    #1;
    if (menu_req === 1'b1)  obs_q.push_back({4'd1, 5'd0, menu_sel});
    if (duty_load === 1'b1) obs_q.push_back({4'd2, duty});
    if (err === 1'b1)       obs_q.push_back({4'd4, 6'd0, err_code});
    if (out_bits !== prev_bits) obs_q.push_back({4'd3, 6'd0, out_bits});
    prev_bits = out_bits;
  end

  // ---------------- reference model ----------------
  logic [7:0] m_line[$];
  int         m_gap;
  logic [2:0] m_sel;
  logic [7:0] m_duty;
  logic [1:0] m_bits;
  logic [1:0] m_code;

  function automatic bit m_is_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic int m_hex_val(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return int'(c) - 87;
  endfunction

  task automatic m_err(input logic [1:0] code);
    m_code = code;
    exp_q.push_back({4'd4, 6'd0, code});
  endtask

  task automatic m_execute();
    int l;
    logic [7:0] c;
    l = m_line.size();
    c = m_line[0];
    if (l > MAXLEN) m_err(2'd2);
    else if (l == 1 && c >= "1" && c <= "5") begin
      m_sel = 3'(int'(c) - 48);
      exp_q.push_back({4'd1, 5'd0, m_sel});
    end else if (l == 1 && (c == "6" || c == "7")) begin
      m_bits = m_bits ^ ((c == "6") ? 2'b01 : 2'b10);
      exp_q.push_back({4'd3, 6'd0, m_bits});
    end else if (c == "D" || c == "d") begin
      if (l == 3 && m_is_hex(m_line[1]) && m_is_hex(m_line[2])) begin
        m_duty = 8'(m_hex_val(m_line[1]) * 16 + m_hex_val(m_line[2]));
        exp_q.push_back({4'd2, m_duty});
      end else m_err(2'd1);
    end else m_err(2'd0);
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_gap = 0;
    if (b == 8'h0D || b == 8'h0A) begin
      if (m_line.size() > 0) begin
        m_execute();
        m_line.delete();
      end
    end else m_line.push_back(b);
  endtask

  task automatic model_idle();
    if (m_line.size() > 0) begin
      m_gap++;
      if (m_gap == TIMEOUT) begin
        m_err(2'd3);
        m_line.delete();
        m_gap = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    model_byte(b);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      model_idle();
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_line.delete();
    m_gap = 0; m_sel = '0; m_duty = '0; m_bits = '0; m_code = '0;
    @(negedge clk);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_all(input string tag);
    int n;
    idle(3);
    chk({tag, "_events"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_event"}, obs_q[i], exp_q[i]);
    chk({tag, "_menu_sel"}, menu_sel, m_sel);
    chk({tag, "_duty"}, duty, m_duty);
    chk({tag, "_out_bits"}, out_bits, m_bits);
    chk({tag, "_err_code"}, err_code, m_code);
    chk({tag, "_busy"}, busy, m_line.size() > 0);
    obs_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [7:0] rnd_hex();
    int v;
    v = $urandom_range(0, 15);
    if (v < 10) return 8'(48 + v);
    return 8'(($urandom_range(0, 1) ? 65 : 97) + v - 10);
  endfunction

  function automatic logic [7:0] rnd_term();
    return $urandom_range(0, 1) ? 8'h0D : 8'h0A;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    do_reset();
    chk("reset_outputs", {menu_req, menu_sel, out_bits, duty, duty_load, err, err_code, busy}, 0);

    // Menu select with exact pulse timing around the terminator edge.
    send_byte("3");
    chk("busy_collect", busy, 1'b1);
    send_byte(8'h0D);
    chk("menu_not_yet", {menu_req, busy}, 2'b00);
    idle(1);
    chk("menu_pulse", {menu_req, menu_sel}, {1'b1, 3'd3});
    idle(1);
    chk("menu_pulse_end", menu_req, 1'b0);
    check_all("menu3");
    send_byte("5"); send_byte(8'h0D); send_byte(8'h0A);
    check_all("menu5_crlf");

    // Toggles.
    send_byte("6"); send_byte(8'h0D); check_all("tog6a");
    send_byte("6"); send_byte(8'h0D); check_all("tog6b");
    send_byte("7"); send_byte(8'h0D); check_all("tog7");
    do_reset();
    chk("reset_bits_duty", {out_bits, duty}, 10'd0);

    // Duty loads and D syntax errors.
    send_byte("D"); send_byte("a"); send_byte("F"); send_byte(8'h0D); check_all("duty_af");
    send_byte("d"); send_byte("1"); send_byte("G"); send_byte(8'h0D); check_all("duty_badhex");
    send_byte("D"); send_byte("1"); send_byte(8'h0D); check_all("duty_short");

    // Overflow then recovery.
    for (int i = 0; i < 6; i++) send_byte("X");
    send_byte(8'h0D); check_all("overflow");
    send_byte("1"); send_byte(8'h0D); check_all("after_overflow");

    // Timeout boundary: 16 idle cycles expire, a byte on the 16th wins.
    send_byte("D");
    idle(TIMEOUT);
    chk("timeout_err", {err, err_code, busy}, {1'b1, 2'd3, 1'b0});
    check_all("timeout");
    send_byte("D");
    idle(TIMEOUT - 1);
    send_byte("1");
    chk("byte_wins", {err, busy}, 2'b01);
    send_byte("2"); send_byte(8'h0D); check_all("no_timeout");

    // Unknown command, then reset in the middle of a line.
    send_byte("Q"); send_byte(8'h0D); check_all("unknown");
    send_byte("D"); send_byte("1");
    do_reset();
    send_byte("2"); send_byte(8'h0D); check_all("abort_line");

    // Random lines.
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 7))
        0: begin send_byte(8'(48 + $urandom_range(1, 5))); send_byte(rnd_term()); end
        1: begin send_byte($urandom_range(0, 1) ? "6" : "7"); send_byte(rnd_term()); end
        2: begin
          send_byte($urandom_range(0, 1) ? "D" : "d");
          send_byte(rnd_hex()); send_byte(rnd_hex()); send_byte(rnd_term());
        end
        3: begin
          send_byte("D");
          for (int k = 0, n = $urandom_range(0, 3); k < n; k++)
            send_byte($urandom_range(0, 2) == 0 ? "G" : rnd_hex());
          send_byte(rnd_term());
        end
        4: begin send_byte(8'($urandom_range(32, 126))); send_byte(rnd_term()); end
        5: begin
          for (int k = 0, n = $urandom_range(5, 7); k < n; k++)
            send_byte(8'($urandom_range(32, 126)));
          send_byte(rnd_term());
        end
        6: begin
          for (int k = 0, n = $urandom_range(1, 3); k < n; k++) send_byte(rnd_hex());
          idle($urandom_range(TIMEOUT - 2, TIMEOUT + 2));
          send_byte(rnd_term());
        end
        default: begin
          send_byte("6"); send_byte(rnd_term());
          send_byte("7"); send_byte(rnd_term());
          send_byte(8'(48 + $urandom_range(1, 5))); send_byte(8'h0D); send_byte(8'h0A);
        end
      endcase
      check_all("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
